// File: rtl/serial_pkg.sv
// Shared types for the serial operand feeder: default width, FSM states and the operand pair.
package serial_pkg;

  localparam int DEF_WIDTH = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  typedef struct packed {
    logic [DEF_WIDTH-1:0] a;
    logic [DEF_WIDTH-1:0] b;
  } pair_t;

endpackage

// File: rtl/operand_fifo.sv
// Small power-of-two FIFO of {a, b} operand pairs with an occupancy counter.
module operand_fifo
  import serial_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [2*WIDTH-1:0]       wdata,
  output logic [2*WIDTH-1:0]       rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);

  logic [2*WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]      wptr;
  logic [AW-1:0]      rptr;
  logic               do_push;
  logic               do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rptr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + AW'(1);
      if (do_pop)  rptr <= rptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage carries no reset; only pointers and occupancy define validity.
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= wdata;
  end

endmodule

// File: rtl/serial_operand_feeder.sv
// Buffers parallel operand pairs and streams them LSB-first with frame markers for a bit-serial adder.
module serial_operand_feeder
  import serial_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in_a,
  input  logic [WIDTH-1:0]         in_b,
  output logic                     ser_valid,
  input  logic                     ser_ready,
  output logic                     ser_a,
  output logic                     ser_b,
  output logic                     ser_first,
  output logic                     ser_last,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int BW = $clog2(WIDTH);
  localparam logic [BW-1:0] LAST = BW'(WIDTH - 1);

  state_t             state;
  logic [WIDTH-1:0]   sh_a;
  logic [WIDTH-1:0]   sh_b;
  logic [BW-1:0]      bitcnt;
  logic [2*WIDTH-1:0] head;
  logic               fifo_full;
  logic               fifo_empty;
  logic               push;
  logic               pop;
  logic               at_last;
  logic               xfer;

  assign in_ready  = !fifo_full;
  assign push      = in_valid && in_ready;
  assign busy      = (state == SHIFT);
  assign xfer      = busy && ser_ready;
  assign at_last   = (bitcnt == LAST);
  assign ser_valid = busy;
  assign ser_a     = sh_a[0];
  assign ser_b     = sh_b[0];
  assign ser_first = busy && (bitcnt == '0);
  assign ser_last  = busy && at_last;

  // Reload on the last transfer keeps frames back-to-back with no idle cycle.
  assign pop = !fifo_empty && ((state == IDLE) || (xfer && at_last));

  operand_fifo #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk  (clk),
    .reset(reset),
    .push (push),
    .pop  (pop),
    .wdata({in_a, in_b}),
    .rdata(head),
    .count(count),
    .full (fifo_full),
    .empty(fifo_empty)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      sh_a   <= '0;
      sh_b   <= '0;
      bitcnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (!fifo_empty) begin
            {sh_a, sh_b} <= head;
            bitcnt       <= '0;
            state        <= SHIFT;
          end
        end
        SHIFT: begin
          if (ser_ready) begin
            if (at_last && !fifo_empty) begin
              {sh_a, sh_b} <= head;
              bitcnt       <= '0;
            end else if (at_last) begin
              sh_a   <= sh_a >> 1;
              sh_b   <= sh_b >> 1;
              bitcnt <= '0;
              state  <= IDLE;
            end else begin
              sh_a   <= sh_a >> 1;
              sh_b   <= sh_b >> 1;
              bitcnt <= bitcnt + BW'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_operand_feeder.sv
// Directed bench for serial_operand_feeder: vector table plus hand-written stall, reset and backpressure sequences.
module tb_serial_operand_feeder;
  import serial_pkg::*;

  localparam int WIDTH = 8;
  localparam int DEPTH = 2;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic             clk = 1'b0;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             ser_valid;
  logic             ser_ready;
  logic             ser_a;
  logic             ser_b;
  logic             ser_first;
  logic             ser_last;
  logic             busy;
  logic [CW-1:0]    count;

  always #5 clk = ~clk;

  serial_operand_feeder #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_a     (in_a),
    .in_b     (in_b),
    .ser_valid(ser_valid),
    .ser_ready(ser_ready),
    .ser_a    (ser_a),
    .ser_b    (ser_b),
    .ser_first(ser_first),
    .ser_last (ser_last),
    .busy     (busy),
    .count    (count)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    int               len;
    int               first_cyc;
  } frame_t;

  typedef struct {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH:0]   sum;
  } vec_t;

  frame_t frames[$];
  int     cyc     = 0;
  int     run     = 0;
  int     max_run = 0;

  // Downstream model: rebuilds each frame's operands from the transferred bits.
  initial begin : monitor
    logic             in_frame;
    logic [WIDTH-1:0] acc_a;
    logic [WIDTH-1:0] acc_b;
    int               idx;
    int               fcyc;
    in_frame = 1'b0;
    acc_a = '0;
    acc_b = '0;
    idx = 0;
    fcyc = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (reset) begin
        in_frame = 1'b0;
        run = 0;
      end else begin
        if (ser_valid) begin
          run++;
          if (run > max_run) max_run = run;
        end else begin
          run = 0;
        end
        if (ser_valid && ser_ready) begin
          if (ser_first) begin
            in_frame = 1'b1;
            idx = 0;
            acc_a = '0;
            acc_b = '0;
            fcyc = cyc;
          end
          if (in_frame) begin
            if (idx < WIDTH) begin
              acc_a[idx] = ser_a;
              acc_b[idx] = ser_b;
            end
            idx++;
            if (ser_last) begin
              frames.push_back('{acc_a, acc_b, idx, fcyc});
              in_frame = 1'b0;
            end
          end
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic push(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    bit ok;
    ok = 1'b0;
    in_a = a;
    in_b = b;
    in_valid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      smp();
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    chk("push_accepted", ok, 1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_frames(input int n);
    for (int i = 0; i < 300; i++) begin
      if (frames.size() >= n) break;
      smp();
    end
    chk("frames_arrived", frames.size() >= n, 1);
  endtask

  task automatic check_frame(input string name, input logic [WIDTH-1:0] a,
                             input logic [WIDTH-1:0] b, input logic [WIDTH:0] sum);
    frame_t f;
    if (frames.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: no frame received, expected a=%0h b=%0h", name, a, b);
    end else begin
      f = frames.pop_front();
      chk({name, "_a"}, f.a, a);
      chk({name, "_b"}, f.b, b);
      chk({name, "_len"}, f.len, WIDTH);
      chk({name, "_sum"}, {1'b0, f.a} + {1'b0, f.b}, sum);
    end
  endtask

  vec_t vecs[6];

  initial begin : main
    logic [WIDTH-1:0] seq_a;
    logic [WIDTH-1:0] seq_b;
    logic             prev_stalled;
    logic             prev_valid;
    logic             prev_a;
    logic             prev_b;
    logic             prev_first;
    bit               leaked;
    bit               found;
    int               k;

    vecs[0] = '{8'hCB, 8'h92, 9'h15D};
    vecs[1] = '{8'hE9, 8'hA1, 9'h18A};
    vecs[2] = '{8'hFF, 8'h01, 9'h100};
    vecs[3] = '{8'h00, 8'h00, 9'h000};
    vecs[4] = '{8'hFF, 8'hFF, 9'h1FE};
    vecs[5] = '{8'h80, 8'h80, 9'h100};

    reset = 1'b1;
    in_valid = 1'b0;
    in_a = '0;
    in_b = '0;
    ser_ready = 1'b1;
    repeat (3) @(posedge clk);
    smp();
    chk("rst_in_ready", in_ready, 1);
    chk("rst_ser_valid", ser_valid, 0);
    chk("rst_ser_first", ser_first, 0);
    chk("rst_ser_last", ser_last, 0);
    chk("rst_ser_a", ser_a, 0);
    chk("rst_ser_b", ser_b, 0);
    chk("rst_busy", busy, 0);
    chk("rst_count", count, 0);
    reset = 1'b0;
    tick();

    // First pair: latency and exact bit sequence.
    seq_a = 8'h25;
    seq_b = 8'h12;
    in_a = seq_a;
    in_b = seq_b;
    in_valid = 1'b1;
    smp();
    chk("t1_in_ready", in_ready, 1);
    tick();
    in_valid = 1'b0;
    smp();
    chk("t1_count_after_push", count, 1);
    chk("t1_not_yet_valid", ser_valid, 0);
    tick();
    smp();
    chk("t1_valid", ser_valid, 1);
    chk("t1_first", ser_first, 1);
    chk("t1_last0", ser_last, 0);
    chk("t1_bit0_a", ser_a, seq_a[0]);
    chk("t1_bit0_b", ser_b, seq_b[0]);
    chk("t1_count_after_pop", count, 0);
    for (int i = 1; i < WIDTH; i++) begin
      tick();
      smp();
      chk("t1_bit_a", ser_a, seq_a[i]);
      chk("t1_bit_b", ser_b, seq_b[i]);
      chk("t1_first_off", ser_first, 0);
      chk("t1_last", ser_last, (i == WIDTH - 1));
    end
    tick();
    smp();
    chk("t1_busy_drop", busy, 0);
    chk("t1_valid_drop", ser_valid, 0);
    check_frame("t1", 8'h25, 8'h12, 9'h037);
    tick();

    for (int v = 0; v < 6; v++) begin
      push(vecs[v].a, vecs[v].b);
      wait_frames(1);
      check_frame("vec", vecs[v].a, vecs[v].b, vecs[v].sum);
      tick();
    end

    // Back-to-back frames from consecutive pushes.
    repeat (4) tick();
    frames.delete();
    max_run = 0;
    push(8'hCB, 8'h92);
    push(8'hE9, 8'hA1);
    wait_frames(2);
    repeat (3) tick();
    chk("b2b_run", max_run, 2 * WIDTH);
    if (frames.size() >= 2)
      chk("b2b_first_gap", frames[1].first_cyc - frames[0].first_cyc, WIDTH);
    check_frame("b2b0", 8'hCB, 8'h92, 9'h15D);
    check_frame("b2b1", 8'hE9, 8'hA1, 9'h18A);

    // Backpressure: fill shifter plus FIFO, then a held-off fourth pair.
    ser_ready = 1'b0;
    push(8'h11, 8'h22);
    push(8'h33, 8'h44);
    push(8'h55, 8'h66);
    smp();
    chk("stall_count", count, 2);
    chk("stall_in_ready", in_ready, 0);
    chk("stall_busy", busy, 1);
    chk("stall_first", ser_first, 1);
    chk("stall_bit0", ser_a, 1);
    tick();
    in_a = 8'h77;
    in_b = 8'h88;
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      smp();
      chk("full_hold_ready", in_ready, 0);
      chk("full_hold_count", count, 2);
      tick();
    end
    ser_ready = 1'b1;
    k = -1;
    for (int i = 0; i < 30; i++) begin
      smp();
      if (in_ready) begin
        k = i;
        break;
      end
      tick();
    end
    chk("full_release_cycle", k, WIDTH);
    tick();
    in_valid = 1'b0;
    wait_frames(4);
    check_frame("ord0", 8'h11, 8'h22, 9'h033);
    check_frame("ord1", 8'h33, 8'h44, 9'h077);
    check_frame("ord2", 8'h55, 8'h66, 9'h0BB);
    check_frame("ord3", 8'h77, 8'h88, 9'h0FF);
    repeat (4) tick();

    // Alternating stalls within one frame.
    frames.delete();
    push(8'hFF, 8'h01);
    prev_stalled = 1'b0;
    prev_valid = 1'b0;
    prev_a = 1'b0;
    prev_b = 1'b0;
    prev_first = 1'b0;
    for (int c = 0; c < 60; c++) begin
      ser_ready = (c % 2) == 1;
      smp();
      if (prev_stalled && prev_valid) begin
        chk("stall_hold_a", ser_a, prev_a);
        chk("stall_hold_b", ser_b, prev_b);
        chk("stall_hold_first", ser_first, prev_first);
      end
      prev_valid = ser_valid;
      prev_a = ser_a;
      prev_b = ser_b;
      prev_first = ser_first;
      prev_stalled = !ser_ready;
      if (frames.size() > 0 && !busy) break;
      tick();
    end
    tick();
    ser_ready = 1'b1;
    wait_frames(1);
    check_frame("toggle", 8'hFF, 8'h01, 9'h100);
    tick();

    // Reset in the middle of a frame with one pair buffered.
    frames.delete();
    push(8'hAA, 8'h55);
    push(8'h0F, 8'hF0);
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      smp();
      if (ser_valid && ser_first) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    chk("mid_frame_started", found, 1);
    repeat (3) begin
      tick();
      smp();
    end
    chk("mid_bit3_count", count, 1);
    chk("mid_bit3_busy", busy, 1);
    reset = 1'b1;
    #1;
    chk("arst_in_ready", in_ready, 1);
    chk("arst_ser_valid", ser_valid, 0);
    chk("arst_ser_first", ser_first, 0);
    chk("arst_ser_last", ser_last, 0);
    chk("arst_ser_a", ser_a, 0);
    chk("arst_ser_b", ser_b, 0);
    chk("arst_busy", busy, 0);
    chk("arst_count", count, 0);
    @(posedge clk);
    smp();
    reset = 1'b0;
    tick();
    leaked = 1'b0;
    for (int i = 0; i < 20; i++) begin
      smp();
      if (ser_valid || busy || count != 0) leaked = 1'b1;
      tick();
    end
    chk("post_reset_quiet", leaked, 0);
    chk("post_reset_no_frames", frames.size(), 0);
    push(8'h12, 8'h34);
    wait_frames(1);
    check_frame("post_reset", 8'h12, 8'h34, 9'h046);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

endmodule
